// File: rtl/fir_pkg.sv
// Shared definitions for the sequential FIR: FSM state encoding and a
// constant ceil-log2 used to sanity-check the parameter set at elaboration.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } fir_state_t;

  // ceil(log2(n)), with clog2(1) = 0
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v * 2;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Signed multiply-accumulate slice. The product is sign-extended to the
// accumulator width before the add; no saturation, no rounding.
module fir_mac_unit #(
  parameter int W    = 8,
  parameter int CW   = 8,
  parameter int ACCW = 18
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clr,
  input  logic                   en,
  input  logic signed [W-1:0]    a,
  input  logic signed [CW-1:0]   b,
  output logic signed [ACCW-1:0] acc
);

  logic signed [W+CW-1:0] prod;
  logic signed [ACCW-1:0] prod_ext;

  assign prod     = a * b;
  assign prod_ext = {{(ACCW-W-CW){prod[W+CW-1]}}, prod};

  // Accumulator: clear wins over enable so a new sample always starts from 0
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  acc <= '0;
    else if (clr)  acc <= '0;
    else if (en)   acc <= acc + prod_ext;
  end

endmodule

// File: rtl/fir_mac_seq.sv
// L-tap direct-form FIR with programmable signed coefficients, using one
// time-multiplexed MAC. One sample per L+2 cycles; output is a one-cycle
// pulse with no backpressure.
//
// state | meaning
// IDLE  | waiting for a sample; coefficient writes accepted
// MAC   | one tap product accumulated per cycle, idx 0..L-1
// DONE  | register accumulator into y and pulse out_valid
module fir_mac_seq
  import fir_pkg::*;
#(
  parameter int W    = 8,
  parameter int CW   = 8,
  parameter int L    = 4,
  parameter int AW   = 2,
  parameter int ACCW = 18
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic signed [W-1:0]    x,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic signed [ACCW-1:0] y,
  output logic                   out_valid,
  input  logic                   c_we,
  input  logic [AW-1:0]          c_addr,
  input  logic signed [CW-1:0]   c_data,
  output logic                   c_ready
);

  if (AW != clog2(L)) begin : g_bad_aw
    $error("fir_mac_seq: AW must equal ceil(log2(L))");
  end
  if (ACCW < W + CW + AW) begin : g_bad_accw
    $error("fir_mac_seq: ACCW too narrow for full-precision sum");
  end

  localparam logic [AW-1:0] LAST_IDX = AW'(L - 1);
  localparam logic [AW:0]   L_EXT    = (AW + 1)'(L);

  fir_state_t state, state_nxt;
  logic [AW-1:0]         idx;
  logic signed [W-1:0]   taps  [L];
  logic signed [CW-1:0]  coefs [L];
  logic signed [ACCW-1:0] acc;
  logic accept, c_wr, mac_clr, mac_en;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)         state_nxt = MAC;
      MAC:     if (idx == LAST_IDX)  state_nxt = DONE;
      DONE:                          state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
  end

  // Output / control decode; addresses beyond L-1 are dropped
  always_comb begin
    in_ready = (state == IDLE);
    c_ready  = (state == IDLE);
    accept   = in_ready && in_valid;
    mac_clr  = accept;
    mac_en   = (state == MAC);
    c_wr     = c_ready && c_we && ({1'b0, c_addr} < L_EXT);
  end

  // Tap delay line moves only on an accepted sample
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < L; k++) taps[k] <= '0;
    end else if (accept) begin
      for (int k = L - 1; k > 0; k--) taps[k] <= taps[k-1];
      taps[0] <= x;
    end
  end

  // Coefficient register file; a write on the accept edge is seen by that sample
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < L; k++) coefs[k] <= '0;
    end else if (c_wr) begin
      coefs[c_addr] <= c_data;
    end
  end

  // Tap index restarts on every accept and steps once per MAC cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    idx <= '0;
    else if (accept) idx <= '0;
    else if (mac_en) idx <= idx + 1'b1;
  end

  fir_mac_unit #(.W(W), .CW(CW), .ACCW(ACCW)) u_mac (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (mac_clr),
    .en      (mac_en),
    .a       (taps[idx]),
    .b       (coefs[idx]),
    .acc     (acc)
  );

  // Output register: y holds between results, out_valid pulses on DONE exit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      y         <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= (state == DONE);
      if (state == DONE) y <= acc;
    end
  end

endmodule

// File: tb/tb_fir_mac_seq.sv
// Bench for fir_mac_seq: behavioural reference model plus per-cycle
// compare, and directed scenarios with hand-computed literal results.
module tb_fir_mac_seq;

  localparam int W    = 8;
  localparam int CW   = 8;
  localparam int L    = 4;
  localparam int AW   = 2;
  localparam int ACCW = 18;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic signed [W-1:0]    x;
  logic                   in_valid;
  logic                   in_ready;
  logic signed [ACCW-1:0] y;
  logic                   out_valid;
  logic                   c_we;
  logic [AW-1:0]          c_addr;
  logic signed [CW-1:0]   c_data;
  logic                   c_ready;

  int compares = 0;
  int errors   = 0;
  int cap[$];

  fir_mac_seq #(.W(W), .CW(CW), .L(L), .AW(AW), .ACCW(ACCW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .x         (x),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y         (y),
    .out_valid (out_valid),
    .c_we      (c_we),
    .c_addr    (c_addr),
    .c_data    (c_data),
    .c_ready   (c_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    compares++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: a busy countdown of L+1 cycles after each accept,
  // output value computed as the plain dot product at accept time.
  int m_taps[L];
  int m_c[L];
  int m_rem;
  int m_pend;
  int m_y;
  bit m_ov;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < L; k++) begin
        m_taps[k] = 0;
        m_c[k]    = 0;
      end
      m_rem  = 0;
      m_pend = 0;
      m_y    = 0;
      m_ov   = 0;
    end else begin
      m_ov = 0;
      if (m_rem > 0) begin
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          m_y  = m_pend;
          m_ov = 1;
        end
      end else begin
        if (c_we && int'(c_addr) < L) m_c[c_addr] = int'(c_data);
        if (in_valid) begin
          for (int k = L - 1; k > 0; k--) m_taps[k] = m_taps[k-1];
          m_taps[0] = int'(x);
          m_pend = 0;
          for (int k = 0; k < L; k++) m_pend = m_pend + m_c[k] * m_taps[k];
          m_rem = L + 1;
        end
      end
    end
  end

  // Per-cycle compare of every output against the model
  always @(negedge clk) begin
    check("in_ready", in_ready, (m_rem == 0));
    check("c_ready", c_ready, (m_rem == 0));
    check("out_valid", out_valid, m_ov);
    check("y", $signed(y), m_y);
    if (out_valid) cap.push_back(int'($signed(y)));
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_timeout", in_ready, 1);
  endtask

  task automatic send(input int xv, input bit we = 0, input int addr = 0, input int data = 0);
    @(negedge clk);
    wait_ready();
    x        = W'(xv);
    in_valid = 1'b1;
    c_we     = we;
    c_addr   = AW'(addr);
    c_data   = CW'(data);
    @(negedge clk);
    in_valid = 1'b0;
    c_we     = 1'b0;
  endtask

  task automatic write_c(input int addr, input int data);
    @(negedge clk);
    wait_ready();
    c_we   = 1'b1;
    c_addr = AW'(addr);
    c_data = CW'(data);
    @(negedge clk);
    c_we = 1'b0;
  endtask

  task automatic drain();
    repeat (8) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_imp[5];
    int accepts;
    exp_imp = '{-1, 4, 4, -1, 0};

    reset_n  = 1'b0;
    x        = '0;
    in_valid = 1'b0;
    c_we     = 1'b0;
    c_addr   = '0;
    c_data   = '0;
    repeat (3) @(negedge clk);
    check("rst_y", $signed(y), 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    reset_n = 1'b1;

    // Impulse response
    write_c(0, -1); write_c(1, 4); write_c(2, 4); write_c(3, -1);
    cap.delete();
    send(1); send(0); send(0); send(0); send(0);
    drain();
    check("imp_count", cap.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < cap.size()) check("imp_y", cap[i], exp_imp[i]);

    // Extremes, full-precision without overflow
    for (int k = 0; k < L; k++) write_c(k, -128);
    cap.delete();
    repeat (4) send(-128);
    repeat (4) send(127);
    drain();
    check("ext_count", cap.size(), 8);
    if (cap.size() == 8) begin
      check("ext_first", cap[0], 16384);
      check("ext_max", cap[3], 65536);
      check("ext_mix", cap[4], 32896);
      check("ext_min", cap[7], -65024);
    end

    // Coefficient writes: ignored while busy, used on the accept edge
    write_c(0, 1); write_c(1, 2); write_c(2, 3); write_c(3, 4);
    cap.delete();
    send(10);
    c_we = 1'b1; c_addr = 2'd0; c_data = 8'sd5;
    @(negedge clk);
    c_we = 1'b0;
    drain();
    send(2, 1, 0, 5);
    drain();
    check("cw_count", cap.size(), 2);
    if (cap.size() == 2) begin
      check("cw_busy_ignored", cap[0], 1153);
      check("cw_accept_edge", cap[1], 919);
    end

    // Reset during MAC aborts the computation
    cap.delete();
    @(negedge clk);
    wait_ready();
    x = 8'sd3;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_y", $signed(y), 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_c_ready", c_ready, 1);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_no_output", cap.size(), 0);
    send(1); send(5);
    drain();
    check("zero_coef_count", cap.size(), 2);
    if (cap.size() == 2) begin
      check("zero_coef_y0", cap[0], 0);
      check("zero_coef_y1", cap[1], 0);
    end

    // Continuous in_valid: one accept per L+2 cycles, refused cycles ignored
    write_c(0, 1); write_c(1, -2); write_c(2, 3); write_c(3, -4);
    cap.delete();
    accepts = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      check("ready_pattern", in_ready, (i % 6 == 0));
      if (in_ready) accepts++;
      in_valid = 1'b1;
      x = W'(i + 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("accept_count", accepts, 4);
    drain();
    check("cont_count", cap.size(), 4);
    if (cap.size() == 4) begin
      check("cont_y0", cap[0], -6);
      check("cont_y1", cap[1], 16);
      check("cont_y2", cap[2], -18);
      check("cont_y3", cap[3], 10);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errors);
    $finish;
  end

endmodule
